div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Round-robin scheduler that time-shares one cordic_div instance (16-bit, Q4.12) among NREQ requesters, e.g. the diagonal reciprocals of the triangular-inverse datapath.
- Replaces one divider per requester with a single divider.
- Arbitrates requests, latches the winner's operands, pulses the divider start, waits for done, and routes quotient/error back to the winner.
- Divider is instantiated outside this block; this block drives its start/operand pins and observes its quotient/done/Error.

Parameters:
- NREQ, 3, number of requesters (2..8)
- WORD_LENGTH, 16, operand/quotient width
- TIMEOUT, 64, watchdog limit in cycles (used only with DIV_WATCHDOG_EN)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  per-requester request level
- req_num  input  NREQ*WORD_LENGTH  packed numerators; requester i at bits [i*W +: W]
- req_den  input  NREQ*WORD_LENGTH  packed denominators, same packing
- rsp_valid  output  NREQ  one-cycle result strobe to the granted requester
- rsp_quot  output  WORD_LENGTH  shared result bus; valid only while some rsp_valid bit is high
- rsp_err  output  1  error flag qualified by rsp_valid
- busy  output  1  high in every state except IDLE
- grant_idx  output  3  index of the current or last winner
- div_start  output  1  start pulse to the divider
- div_num  output  WORD_LENGTH  divider numerator
- div_den  output  WORD_LENGTH  divider denominator
- div_quot  input  WORD_LENGTH  divider quotient
- div_done  input  1  divider completion
- div_err  input  1  divider Error

Behaviour:
- Reset (async, any state): state=IDLE, ptr=0, and all outputs 0 (rsp_valid, rsp_quot, rsp_err, busy, grant_idx, div_start, div_num, div_den).
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If req is nonzero, grant the first set bit searching ptr, ptr+1, … with wrap modulo NREQ.
  - Register grant_idx, div_num and div_den from the winner's operands; go to LAUNCH.
  - If req==0, stay in IDLE.
- LAUNCH:
  - div_start=1 for exactly this cycle; go to WAIT.
  - div_done is ignored here, because it can be stale from the previous operation.
- WAIT:
  - div_start=0.
  - When div_done=1, capture rsp_quot<=div_quot and rsp_err<=div_err; go to RESP.
- RESP:
  - rsp_valid[grant_idx]=1 for one cycle.
  - ptr<=(grant_idx+1) mod NREQ; go to IDLE.
- Operand hold: div_num and div_den hold their values from grant until the next grant. Requester operands are sampled only at grant, so a requester may change operands after grant.
- Request protocol: a requester holds req until it sees its rsp_valid, then deasserts it in the following cycle. req is not sampled in LAUNCH, WAIT or RESP.
- A requester that keeps req high after its response re-enters arbitration behind the other requesters (round-robin fairness).
- Req dropped mid-flight: the operation completes and rsp_valid is still issued; the requester may ignore it.
- Latency: req seen in IDLE at edge 0 → div_start high in cycle 1 → rsp_valid one cycle after div_done is sampled in WAIT. Minimum req-to-rsp time is 3 + divider latency.
- Back-to-back: after RESP, IDLE takes one cycle before the next grant. The service interval is therefore 4 + divider latency.
- rsp_quot and rsp_err hold their values until the next RESP.
- Reset mid-operation: the divider is not aborted by this block (it shares rst). Any later div_done from the abandoned operation arrives while this block is in IDLE or LAUNCH and is ignored.

Optional Feature:
- Macro DIV_WATCHDOG_EN.
- When defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without div_done, go to RESP with rsp_quot=0 and rsp_err=1.
- When undefined: no counter, and WAIT has no exit except div_done.

Test Plan:
- Single request: req=3'b001, num0=0x2000, den0=0x1000; divider model with done 16 cycles after start returning 0x2000 → div_start single pulse in cycle 1; rsp_valid=3'b001 with rsp_quot=0x2000, rsp_err=0 at cycle 19.
- Simultaneous requests: req=3'b111 held, per-requester operands distinct → grant order 0,1,2, each requester gets exactly one rsp_valid with its own quotient; div_start count=3.
- Fairness: req0 held high permanently, req2 raised after the first grant → sequence 0,2,0 with no second consecutive grant to requester 0.
- Divider error: model returns div_err=1 with den=0x0000 → rsp_err=1 on the rsp_valid cycle; the next request returns rsp_err=0.
- Stale done: pulse div_done during LAUNCH → no transition until the real done; rsp_quot equals the real quotient.
- Async reset asserted in WAIT → all outputs 0 immediately without a clock; after release, req=3'b010 is granted first (ptr=0 search finds requester 1). With DIV_WATCHDOG_EN, TIMEOUT=64 and the divider never completing → rsp_valid with rsp_err=1 and rsp_quot=0 after 64 WAIT cycles.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin scheduler that time-shares one external cordic_div among NREQ requesters.
// Optional watchdog on the divider wait is enabled by defining DIV_WATCHDOG_EN.
module div_share_arbiter #(
  parameter int NREQ        = 3,
  parameter int WORD_LENGTH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*WORD_LENGTH-1:0] req_num,
  input  logic [NREQ*WORD_LENGTH-1:0] req_den,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [WORD_LENGTH-1:0]      rsp_quot,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [2:0]                  grant_idx,
  output logic                        div_start,
  output logic [WORD_LENGTH-1:0]      div_num,
  output logic [WORD_LENGTH-1:0]      div_den,
  input  logic [WORD_LENGTH-1:0]      div_quot,
  input  logic                        div_done,
  input  logic                        div_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               ptr;
  logic [7:0]               req_pad;
  logic [2:0]               cand;
  logic                     win_found;
  logic [2:0]               win_idx;
  logic [WORD_LENGTH-1:0]   win_num, win_den;
  logic [7:0]               rsp_onehot;
  logic                     wd_expired;

`ifdef DIV_WATCHDOG_EN
  logic [7:0] wd_cnt;

  // Held at zero outside WAIT, so it effectively clears on WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wd_cnt <= '0;
    else if (state != WAIT) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 8'd1;
  end

  assign wd_expired = (state == WAIT) && (wd_cnt == 8'(TIMEOUT - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // Rotating priority search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    req_pad   = 8'(req);
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = 3'((32'(ptr) + k) % NREQ);
      if (!win_found && req_pad[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_num = req_num[int'(win_idx)*WORD_LENGTH +: WORD_LENGTH];
  assign win_den = req_den[int'(win_idx)*WORD_LENGTH +: WORD_LENGTH];

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;   // a stale div_done from the previous op is ignored here
      WAIT:    if (div_done || wd_expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_onehot = 8'b1 << grant_idx;

  always_comb begin
    busy      = (state != IDLE);
    div_start = (state == LAUNCH);
    rsp_valid = '0;
    if (state == RESP) rsp_valid = rsp_onehot[NREQ-1:0];
  end

  // Grant bookkeeping, operand latch and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      grant_idx <= '0;
      div_num   <= '0;
      div_den   <= '0;
      rsp_quot  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            div_num   <= win_num;
            div_den   <= win_den;
          end
        end
        WAIT: begin
          if (div_done) begin
            rsp_quot <= div_quot;
            rsp_err  <= div_err;
          end else if (wd_expired) begin
            rsp_quot <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RESP:    ptr <= 3'((32'(grant_idx) + 1) % NREQ);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter with a behavioural Q4.12 divider model.
// Define DIV_WATCHDOG_EN for both files to exercise the watchdog path.
module tb_div_share_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 16;
  localparam int LAT  = 16;
  localparam int TO   = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] req_num, req_den;
  logic [NREQ-1:0] rsp_valid;
  logic [W-1:0]    rsp_quot;
  logic            rsp_err, busy, div_start, div_done, div_err;
  logic [2:0]      grant_idx;
  logic [W-1:0]    div_num, div_den, div_quot;

  always #5 clk = ~clk;

  div_share_arbiter #(.NREQ(NREQ), .WORD_LENGTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_num(req_num), .req_den(req_den),
    .rsp_valid(rsp_valid), .rsp_quot(rsp_quot), .rsp_err(rsp_err), .busy(busy),
    .grant_idx(grant_idx), .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_quot(div_quot), .div_done(div_done), .div_err(div_err)
  );

  // Divider model: done pulses LAT cycles after start; den=0 gives 0x7FFF with error.
  logic       hang = 1'b0;
  logic       stale = 1'b0;
  logic       stale_arm = 1'b0;
  int         cnt = 0;
  logic       done_r = 1'b0, err_r = 1'b0, err_n = 1'b0;
  logic [W-1:0] quot_r = '0, quot_n = '0;

  function automatic logic [W-1:0] qdiv(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [27:0] w;
    if (d == '0) return 16'h7FFF;
    w = {n, 12'h000} / {12'h000, d};
    return w[15:0];
  endfunction

  always @(posedge clk) begin
    done_r <= 1'b0;
    if (div_start) begin
      cnt    <= LAT;
      quot_n <= qdiv(div_num, div_den);
      err_n  <= (div_den == '0);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !hang) begin
        done_r <= 1'b1;
        quot_r <= quot_n;
        err_r  <= err_n;
      end
    end
  end

  assign div_done = done_r | stale;
  assign div_quot = stale ? 16'hDEAD : quot_r;
  assign div_err  = stale ? 1'b0 : err_r;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]   idx;
    logic [W-1:0] quot;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic done_prev = 1'b0;
  logic start_prev = 1'b0;
  int   start_count = 0;

  // Monitor: pops one expectation per response strobe.
  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'd1 << e.idx);
        check("rsp_quot", 64'(rsp_quot), 64'(e.quot));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        if (!hang) check("rsp_after_done", 64'(done_prev), 64'd1);
      end
    end
    if (div_start) begin
      check("start_single_pulse", 64'(start_prev), 64'd0);
      start_count++;
    end
    done_prev  = div_done;
    start_prev = div_start;
  end

  int              rsp_seen = 0;
  logic [NREQ-1:0] hold = '0;

  // One cycle: requesters drop req after their response unless held.
  task automatic step();
    @(negedge clk);
    rsp_seen += $countones(rsp_valid);
    req = req & ~(rsp_valid & ~hold);
    stale = stale_arm && div_start;
    if (stale) stale_arm = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    int n = 0;
    while (rsp_seen < target && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(rsp_seen), 64'(target));
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
    req_num[i*W +: W] = n;
    req_den[i*W +: W] = d;
  endtask

  task automatic expect_rsp(input logic [2:0] idx, input logic [W-1:0] q, input logic err);
    exp_t x;
    x.idx = idx; x.quot = q; x.err = err;
    sb.push_back(x);
  endtask

  int base;
  int s0;

  initial begin
    req = '0; req_num = '0; req_den = '0;
    rst = 1'b1;
    step(); step();
    check("reset_outputs", {rsp_valid, rsp_quot, rsp_err, busy, grant_idx, div_start, div_num, div_den}, 64'd0);
    rst = 1'b0;
    step();

    // Single request.
    set_ops(0, 16'h2000, 16'h1000);
    expect_rsp(3'd0, 16'h2000, 1'b0);
    req = 3'b001;
    step();
    check("t1_launch", {busy, div_start, grant_idx}, {1'b1, 1'b1, 3'd0});
    check("t1_operands", {div_num, div_den}, 32'h2000_1000);
    wait_rsp(1, 40, "t1_done");
    step();
    check("t1_idle", {busy, div_start}, 2'b00);

    // Simultaneous requests from a fresh reset: order 0,1,2.
    rst = 1'b1; step(); rst = 1'b0;
    set_ops(0, 16'h1000, 16'h1000);
    set_ops(1, 16'h3000, 16'h1000);
    set_ops(2, 16'h1000, 16'h2000);
    expect_rsp(3'd0, 16'h1000, 1'b0);
    expect_rsp(3'd1, 16'h3000, 1'b0);
    expect_rsp(3'd2, 16'h0800, 1'b0);
    base = rsp_seen; s0 = start_count;
    req = 3'b111;
    wait_rsp(base + 3, 120, "t2_done");
    step(); step();
    check("t2_starts", 64'(start_count - s0), 64'd3);
    check("t2_idle", 64'(busy), 64'd0);

    // Fairness: requester 0 holds req, requester 2 joins after first grant.
    set_ops(0, 16'h1000, 16'h1000);
    set_ops(2, 16'h1000, 16'h2000);
    expect_rsp(3'd0, 16'h1000, 1'b0);
    expect_rsp(3'd2, 16'h0800, 1'b0);
    expect_rsp(3'd0, 16'h1000, 1'b0);
    base = rsp_seen;
    hold = 3'b001;
    req = 3'b001;
    step();
    req[2] = 1'b1;
    wait_rsp(base + 3, 120, "t3_done");
    hold = '0;
    req = '0;
    step(); step();
    check("t3_idle", 64'(busy), 64'd0);

    // Divider error, then a clean request.
    set_ops(1, 16'h1000, 16'h0000);
    expect_rsp(3'd1, 16'h7FFF, 1'b1);
    base = rsp_seen;
    req = 3'b010;
    wait_rsp(base + 1, 40, "t4_err_done");
    step();
    set_ops(1, 16'h0800, 16'h1000);
    expect_rsp(3'd1, 16'h0800, 1'b0);
    req = 3'b010;
    wait_rsp(base + 2, 40, "t4_ok_done");
    step();

    // Stale done during LAUNCH must be ignored.
    set_ops(0, 16'h3000, 16'h2000);
    expect_rsp(3'd0, 16'h1800, 1'b0);
    base = rsp_seen;
    stale_arm = 1'b1;
    req = 3'b001;
    step();
    step();
    step();
    check("t5_still_waiting", {busy, rsp_valid}, {1'b1, 3'b000});
    wait_rsp(base + 1, 40, "t5_done");
    step();

    // Async reset in WAIT clears outputs without a clock edge.
    set_ops(2, 16'h2000, 16'h1000);
    req = 3'b100;
    step(); step(); step();
    check("t6_in_wait", {busy, div_start, grant_idx}, {1'b1, 1'b0, 3'd2});
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_reset", {rsp_valid, rsp_quot, rsp_err, busy, grant_idx, div_start, div_num, div_den}, 64'd0);
    req = '0;
    step(); step();
    rst = 1'b0;
    set_ops(1, 16'h1000, 16'h0400);
    expect_rsp(3'd1, 16'h4000, 1'b0);
    base = rsp_seen;
    req = 3'b010;
    step();
    check("t6_first_grant", {div_start, grant_idx}, {1'b1, 3'd1});
    wait_rsp(base + 1, 40, "t6_done");
    step();

`ifdef DIV_WATCHDOG_EN
    begin
      int wc = 0;
      int n = 0;
      hang = 1'b1;
      set_ops(0, 16'h1000, 16'h1000);
      expect_rsp(3'd0, 16'h0000, 1'b1);
      base = rsp_seen;
      req = 3'b001;
      while (rsp_seen < base + 1 && n < 200) begin
        step();
        n++;
        if (busy && !div_start && rsp_valid == '0) wc++;
      end
      check("wd_done", 64'(rsp_seen), 64'(base + 1));
      check("wd_wait_cycles", 64'(wc), 64'(TO));
      step();
      hang = 1'b0;
    end
`endif

    step(); step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
